// File: rtl/alu_result_streamer_pkg.sv
// Shared types and widths for the ALU result byte streamer.
// Optional change filter is enabled by defining RESULT_CHANGE_FILTER_EN.
package alu_result_streamer_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// Word FIFO with extra-MSB pointers and a registered occupancy count.
// Read data is the combinational head so the serializer can load it on the pop edge.
module result_fifo #(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Both qualifiers look only at registered state, so a pop never frees room for a same-cycle push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign level = level_q;

endmodule

// File: rtl/alu_result_streamer.sv
// Captures ALU result words into a FIFO and streams them MSB byte first on a valid/ready port.
// Define RESULT_CHANGE_FILTER_EN to accept only captures that differ from the last accepted word.
module alu_result_streamer
    import alu_result_streamer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic [CNT_W-1:0]  level_o,
    output logic              overflow_o,
    output logic              busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overflow_q, overflow_d;

    logic              fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;
    logic              accept, push, pop, handshake;

`ifdef RESULT_CHANGE_FILTER_EN
    logic [WORD_W-1:0] last_q;
    logic              last_valid_q;

    assign accept = capture_i && (!last_valid_q || (data_i != last_q));

    // The compare word tracks what actually entered the FIFO, not what was offered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else if (push) begin
            last_q       <= data_i;
            last_valid_q <= 1'b1;
        end
    end
`else
    assign accept = capture_i;
`endif

    assign push      = accept && !fifo_full;
    assign pop       = (state_q == IDLE) && !fifo_empty;
    assign handshake = (state_q == SEND) && byte_ready_i;

    result_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data_i),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | (accept && fifo_full);
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    shift_d = fifo_rdata;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        shift_d = shift_q << BYTE_W;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_valid_o = 1'b0;
        busy_o       = 1'b0;
        byte_o       = '0;
        if (state_q == SEND) begin
            byte_valid_o = 1'b1;
            busy_o       = 1'b1;
            byte_o       = shift_q[WORD_W-1 -: BYTE_W];
        end
    end

    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_alu_result_streamer.sv
// Scoreboard bench for alu_result_streamer; filter scenario follows RESULT_CHANGE_FILTER_EN.
module tb_alu_result_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        capture_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b0;
    logic [3:0]  level_o;
    logic        overflow_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_count = 0;
    logic [7:0] exp_q [$];

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_byte  = '0;

    always #5 clk = ~clk;

    alu_result_streamer #(.DEPTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .capture_i    (capture_i),
        .data_i       (data_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .level_o      (level_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        capture_i = 1'b0;
        byte_ready_i = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Drives one capture cycle; accepted words are queued as their four expected bytes.
    task automatic cap(input logic [31:0] w, input bit accepted);
        capture_i = 1'b1;
        data_i = w;
        if (accepted) begin
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
        end
        tick();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !busy_o) break;
            tick();
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: score every handshake and verify the offer is held while stalled.
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(byte_valid_o), 32'd1);
                check("hold_byte", 32'(byte_o), 32'(prev_byte));
            end
            if (byte_valid_o && byte_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(byte_o), 32'hFFFF_FFFF);
                end else begin
                    check("byte", 32'(byte_o), 32'(exp_q.pop_front()));
                end
                $display("hs %0d byte=%02h level=%0d", hs_count, byte_o, level_o);
                hs_count++;
            end
            prev_valid <= byte_valid_o;
            prev_ready <= byte_ready_i;
            prev_byte  <= byte_o;
        end
    end

    initial begin
        int base;
        bit seen;

        // Reset then idle
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(byte_valid_o), 32'd0);
            check("idle_level", 32'(level_o), 32'd0);
            check("idle_busy", 32'(busy_o), 32'd0);
        end
        check("idle_byte", 32'(byte_o), 32'd0);
        check("idle_ovf", 32'(overflow_o), 32'd0);
        tick();

        // Single word with ready held high: latency and consecutive bytes
        byte_ready_i = 1'b1;
        base = hs_count;
        capture_i = 1'b1;
        data_i = 32'hDEADBEEF;
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        @(negedge clk);
        check("lat_n_valid", 32'(byte_valid_o), 32'd0);
        tick();
        capture_i = 1'b0;
        @(negedge clk);
        check("lat_n1_level", 32'(level_o), 32'd1);
        check("lat_n1_valid", 32'(byte_valid_o), 32'd0);
        tick();
        @(negedge clk);
        check("lat_n2_valid", 32'(byte_valid_o), 32'd1);
        check("lat_n2_byte", 32'(byte_o), 32'hDE);
        check("lat_n2_level", 32'(level_o), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("seq_valid", 32'(byte_valid_o), 32'd1);
        end
        tick();
        @(negedge clk);
        check("busy_fall", 32'(busy_o), 32'd0);
        check("single_hs", 32'(hs_count - base), 32'd4);
        tick();

        // Back-pressure with ready pattern 1,0,0 repeating
        base = hs_count;
        byte_ready_i = 1'b0;
        cap(32'h01020304, 1'b1);
        capture_i = 1'b0;
        for (int i = 0; i < 60; i++) begin
            byte_ready_i = (i % 3 == 0);
            tick();
            if (exp_q.size() == 0 && !busy_o) break;
        end
        byte_ready_i = 1'b1;
        drain("bp_drain");
        check("bp_hs", 32'(hs_count - base), 32'd4);

        // Overflow: ten captures into a depth-8 FIFO while stalled
        do_reset();
        base = hs_count;
        for (int w = 1; w <= 10; w++) cap(32'(w), w <= 9);
        capture_i = 1'b0;
        @(negedge clk);
        check("ovf_level", 32'(level_o), 32'd8);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_busy", 32'(busy_o), 32'd1);
        tick();
        byte_ready_i = 1'b1;
        drain("ovf_drain");
        check("ovf_hs", 32'(hs_count - base), 32'd36);
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        check("ovf_level_end", 32'(level_o), 32'd0);

        // Reset in the middle of a word
        do_reset();
        byte_ready_i = 1'b1;
        base = hs_count;
        cap(32'hCAFEF00D, 1'b1);
        capture_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (hs_count - base >= 2) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("mid_two_bytes", 32'(seen), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("mid_valid", 32'(byte_valid_o), 32'd0);
        check("mid_level", 32'(level_o), 32'd0);
        check("mid_ovf", 32'(overflow_o), 32'd0);
        check("mid_busy", 32'(busy_o), 32'd0);
        base = hs_count;
        for (int i = 0; i < 10; i++) tick();
        check("mid_no_more", 32'(hs_count - base), 32'd0);

        // Change filter: 5,5,7,7,5
        do_reset();
        byte_ready_i = 1'b1;
        base = hs_count;
`ifdef RESULT_CHANGE_FILTER_EN
        cap(32'd5, 1'b1); cap(32'd5, 1'b0); cap(32'd7, 1'b1); cap(32'd7, 1'b0); cap(32'd5, 1'b1);
        capture_i = 1'b0;
        drain("filt_drain");
        check("filt_hs", 32'(hs_count - base), 32'd12);
`else
        cap(32'd5, 1'b1); cap(32'd5, 1'b1); cap(32'd7, 1'b1); cap(32'd7, 1'b1); cap(32'd5, 1'b1);
        capture_i = 1'b0;
        drain("nofilt_drain");
        check("nofilt_hs", 32'(hs_count - base), 32'd20);
`endif
        check("filt_ovf", 32'(overflow_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
